// File: rtl/imm_extend_stage.sv
// Registered immediate extender for the pipelined MIPS decode path.
// Extends an IN_W-bit immediate to OUT_W bits according to a mode code and
// carries a destination tag. A main register plus one skid register let the
// stage sustain one result per cycle while keeping in_ready a registered signal.
// Parameters must satisfy OUT_W >= IN_W + 2.
module imm_extend_stage #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_imm;
    logic             ext_err;

    logic             main_valid_q, main_valid_d;
    logic [OUT_W-1:0] main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             main_err_q, main_err_d;

    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_err_q, skid_err_d;

    logic             in_ready_q, in_ready_d;
    logic             in_hs;
    logic             out_hs;

    // Extension happens before storage so held entries are already final.
    always_comb begin
        sext    = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
        ext_imm = '0;
        ext_err = 1'b0;
        case (in_mode)
            3'd0:    ext_imm = {{EXT_W{1'b0}}, in_imm};
            3'd1:    ext_imm = sext;
            3'd2:    ext_imm = {in_imm, {EXT_W{1'b0}}};
            3'd3:    ext_imm = {sext[OUT_W-3:0], 2'b00};
            default: ext_err = 1'b1;
        endcase
    end

    // Main/skid next-state: flush wins, then drain, then accept.
    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;

        in_hs  = in_valid & in_ready_q;
        out_hs = main_valid_q & out_ready;

        if (flush) begin
            // Data registers keep their last value so out_* stay stable.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_hs) begin
            if (skid_valid_q) begin
                // in_hs cannot occur here because in_ready_q is low.
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_tag_d   = skid_tag_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (in_hs) begin
                main_valid_d = 1'b1;
                main_imm_d   = ext_imm;
                main_tag_d   = in_tag;
                main_err_d   = ext_err;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_hs) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = ext_imm;
                main_tag_d   = in_tag;
                main_err_d   = ext_err;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = ext_imm;
                skid_tag_d   = in_tag;
                skid_err_d   = ext_err;
            end
        end

        in_ready_d = ~skid_valid_d;
    end

    // State registers; async reset empties both entries and clears outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_imm   = main_imm_q;
    assign out_tag   = main_tag_q;
    assign out_err   = main_err_q;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: mode vector table, streaming,
// back-pressure, flush and reset sequences, plus a 12/24-bit instance.
module tb_imm_extend_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;
    logic        out_err;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [11:0] b_in_imm;
    logic [2:0]  b_in_mode;
    logic [4:0]  b_in_tag;
    logic        b_flush;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [23:0] b_out_imm;
    logic [4:0]  b_out_tag;
    logic        b_out_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] drv_exp;
    logic        drv_err;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic        err;
    } sb_t;
    sb_t sb[$];
    sb_t e;

    typedef struct {
        logic [15:0] imm;
        logic [2:0]  mode;
        logic [4:0]  tag;
        logic [31:0] exp;
        logic        err;
    } vec_t;
    vec_t vt[8];

    imm_extend_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_err(out_err)
    );

    imm_extend_stage #(.IN_W(12), .OUT_W(24), .TAG_W(5)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_imm(b_in_imm), .in_mode(b_in_mode), .in_tag(b_in_tag), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_tag(b_out_tag), .out_err(b_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference extension for the 16 -> 32 configuration.
    function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic [2:0] mode);
        case (mode)
            3'd0:    return {16'h0000, imm};
            3'd1:    return {{16{imm[15]}}, imm};
            3'd2:    return {imm, 16'h0000};
            3'd3:    return {{14{imm[15]}}, imm, 2'b00};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] imm, input logic [2:0] mode, input logic [4:0] tag);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        drv_exp  = ext_model(imm, mode);
        drv_err  = (mode > 3'd3);
    endtask

    // Scoreboard: push on accepted input, pop/compare on delivered output.
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(in_valid && in_ready && out_valid && out_ready && dut.skid_valid_q))
            else begin
                bad++;
                $error("FAIL hs_conflict actual=1 required=0");
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra actual tag=%0d required=no output", out_tag);
                end else begin
                    e = sb.pop_front();
                    check("sb_imm", out_imm, e.imm);
                    check("sb_tag", {27'd0, out_tag}, {27'd0, e.tag});
                    check("sb_err", {31'd0, out_err}, {31'd0, e.err});
                end
            end
            if (in_valid && in_ready && !flush) sb.push_back('{drv_exp, in_tag, drv_err});
            if (flush) sb.delete();
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{16'h8004, 3'd0, 5'd3,  32'h00008004, 1'b0};
        vt[1] = '{16'h8004, 3'd1, 5'd4,  32'hFFFF8004, 1'b0};
        vt[2] = '{16'h8004, 3'd2, 5'd5,  32'h80040000, 1'b0};
        vt[3] = '{16'h8004, 3'd3, 5'd6,  32'hFFFE0010, 1'b0};
        vt[4] = '{16'h8004, 3'd5, 5'd7,  32'h00000000, 1'b1};
        vt[5] = '{16'h7FFF, 3'd1, 5'd8,  32'h00007FFF, 1'b0};
        vt[6] = '{16'h7FFF, 3'd3, 5'd9,  32'h0001FFFC, 1'b0};
        vt[7] = '{16'h1234, 3'd7, 5'd10, 32'h00000000, 1'b1};

        rst = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b1; drv_exp = '0; drv_err = 1'b0;
        b_in_valid = 1'b0; b_in_imm = '0; b_in_mode = '0; b_in_tag = '0;
        b_flush = 1'b0; b_out_ready = 1'b1;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_tag", {27'd0, out_tag}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        step();
        rst = 1'b0;

        // Mode table, one entry at a time
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_imm = vt[i].imm; in_mode = vt[i].mode; in_tag = vt[i].tag;
            drv_exp = vt[i].exp; drv_err = vt[i].err;
            step();
            in_valid = 1'b0;
            @(negedge clk);
            check("mode_valid", {31'd0, out_valid}, 32'd1);
            check("mode_imm", out_imm, vt[i].exp);
            check("mode_err", {31'd0, out_err}, {31'd0, vt[i].err});
            check("mode_tag", {27'd0, out_tag}, {27'd0, vt[i].tag});
            step();
        end

        // Streaming, 8 back-to-back
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(16'($urandom), 3'(i % 4), 5'(16 + i));
            @(negedge clk);
            check("stream_ready", {31'd0, in_ready}, 32'd1);
            if (i > 0) begin
                check("stream_valid", {31'd0, out_valid}, 32'd1);
                check("stream_tag", {27'd0, out_tag}, 32'(16 + i - 1));
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_tag", {27'd0, out_tag}, 32'd23);
        step();
        @(negedge clk);
        check("stream_idle", {31'd0, out_valid}, 32'd0);

        // Back-pressure: tags 1,2 held, 3 waits
        out_ready = 1'b0;
        drive(16'h0011, 3'd1, 5'd1);
        step();
        drive(16'h0022, 3'd0, 5'd2);
        step();
        drive(16'hF033, 3'd3, 5'd3);
        @(negedge clk);
        check("bp_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_hold_tag", {27'd0, out_tag}, 32'd1);
        check("bp_hold_imm", out_imm, 32'h00000011);
        step();
        @(negedge clk);
        check("bp_ready_low2", {31'd0, in_ready}, 32'd0);
        check("bp_hold_tag2", {27'd0, out_tag}, 32'd1);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_still_low", {31'd0, in_ready}, 32'd0);
        step();
        @(negedge clk);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_tag", {27'd0, out_tag}, 32'd2);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_tag3", {27'd0, out_tag}, 32'd3);
        step();
        @(negedge clk);
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Flush with skid full
        out_ready = 1'b0;
        drive(16'h0007, 3'd0, 5'd7);
        step();
        drive(16'h0008, 3'd0, 5'd8);
        step();
        drive(16'h0009, 3'd0, 5'd9);
        flush = 1'b1;
        @(negedge clk);
        check("fl_skid_full", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ready", {31'd0, in_ready}, 32'd1);
        step();
        step();
        @(negedge clk);
        check("fl_no_tag9", {31'd0, out_valid}, 32'd0);

        // Flush with main full: output handshake delivered, input handshake dropped
        drive(16'h000C, 3'd0, 5'd12);
        step();
        drive(16'h000B, 3'd0, 5'd11);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl2_valid", {31'd0, out_valid}, 32'd0);
        check("fl2_held_imm", out_imm, 32'h0000000C);

        // Reset between edges with both entries full
        out_ready = 1'b0;
        drive(16'h8004, 3'd3, 5'd4);
        step();
        drive(16'h8005, 3'd1, 5'd5);
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_out_imm", out_imm, 32'd0);
        check("mr_out_tag", {27'd0, out_tag}, 32'd0);
        check("mr_out_err", {31'd0, out_err}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("mr_stays_empty", {31'd0, out_valid}, 32'd0);

        // 12 -> 24 configuration
        for (int i = 0; i < 3; i++) begin
            logic [2:0]  md;
            logic [23:0] ex;
            md = (i == 0) ? 3'd1 : (i == 1) ? 3'd3 : 3'd2;
            ex = (i == 0) ? 24'hFFFFFF : (i == 1) ? 24'hFFFFFC : 24'hFFF000;
            b_in_valid = 1'b1; b_in_imm = 12'hFFF; b_in_mode = md; b_in_tag = 5'(20 + i);
            step();
            b_in_valid = 1'b0;
            @(negedge clk);
            check("w12_valid", {31'd0, b_out_valid}, 32'd1);
            check("w12_imm", {8'd0, b_out_imm}, {8'd0, ex});
            check("w12_tag", {27'd0, b_out_tag}, 32'(20 + i));
            step();
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
